// File: rtl/seg_display_pkg.sv
// Shared types, symbol constants and the 7-segment glyph table for the
// serial segment display path.
package seg_display_pkg;

    localparam int SYM_W = 5;
    localparam logic [SYM_W-1:0] SYM_BLANK = 5'd16;
    localparam logic [3:0]       SYM_ERR   = 4'hE;

    typedef enum logic [2:0] {
        IDLE,
        CONVERT,
        LOAD,
        SHIFT,
        LATCH
    } state_e;

    // Segment bit 0 = a ... bit 6 = g; anything outside 0..15 is dark.
    function automatic logic [6:0] seg7(input logic [SYM_W-1:0] sym);
        logic [6:0] seg;
        case (sym)
            5'd0:    seg = 7'h3F;
            5'd1:    seg = 7'h06;
            5'd2:    seg = 7'h5B;
            5'd3:    seg = 7'h4F;
            5'd4:    seg = 7'h66;
            5'd5:    seg = 7'h6D;
            5'd6:    seg = 7'h7D;
            5'd7:    seg = 7'h07;
            5'd8:    seg = 7'h7F;
            5'd9:    seg = 7'h6F;
            5'd10:   seg = 7'h77;
            5'd11:   seg = 7'h7C;
            5'd12:   seg = 7'h39;
            5'd13:   seg = 7'h5E;
            5'd14:   seg = 7'h79;
            5'd15:   seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_serial_display_if.sv
// Request/status and serial pin bundle between the sensor decode logic
// and the display driver.
interface seg_serial_display_if #(
    parameter int VAL_W = 10
);
    logic [VAL_W-1:0] value;
    logic             oor;
    logic [2:0]       dp_pos;
    logic             start;
    logic             busy;
    logic             done;
    logic             seg_ser;
    logic             seg_clk;
    logic             seg_latch;

    modport master (
        output value, oor, dp_pos, start,
        input  busy, done, seg_ser, seg_clk, seg_latch
    );

    modport slave (
        input  value, oor, dp_pos, start,
        output busy, done, seg_ser, seg_clk, seg_latch
    );
endinterface

// File: rtl/bcd_dd_conv.sv
// Sequential double-dabble binary-to-BCD converter: one bit per cycle,
// VAL_W cycles per conversion, sticky overflow when the result needs more digits.
module bcd_dd_conv #(
    parameter int VAL_W  = 10,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [VAL_W-1:0]      value,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;

    logic [VAL_W-1:0] bin_q;
    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] adj;
    logic [CNT_W-1:0] cnt_q;
    logic             active_q;
    logic             ovf_q;

    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign adj  = dd_adjust(bcd_q);
    // High during the cycle whose edge commits the final step, so the
    // result is stable in the cycle right after.
    assign done = active_q && (cnt_q == CNT_W'(VAL_W - 1));
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (start) begin
            bin_q    <= value;
            bcd_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b1;
            ovf_q    <= 1'b0;
        end else if (active_q) begin
            // A one leaving the top nibble means the value needs another digit.
            bin_q    <= bin_q << 1;
            bcd_q    <= {adj[BCD_W-2:0], bin_q[VAL_W-1]};
            ovf_q    <= ovf_q | adj[BCD_W-1];
            cnt_q    <= cnt_q + CNT_W'(1);
            if (done) active_q <= 1'b0;
        end
    end

endmodule

// File: rtl/seg_serial_display.sv
// Reading-to-serial 7-segment driver: BCD conversion, glyph/frame build and
// clocked shift-out to an external shift-register chain with a latch strobe.
module seg_serial_display
    import seg_display_pkg::*;
#(
    parameter int         NUM_DIGITS   = 4,
    parameter int         VAL_W        = 10,
    parameter int         CLK_DIV_LOG2 = 10,
    parameter logic [3:0] UNIT_CODE    = 4'hC,
    parameter bit         BLANK_LZ     = 1'b1,
    parameter bit         INVERT_SER   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg_serial_display_if.slave  bus
);

    localparam int FRAME_W = 8 * NUM_DIGITS;
    localparam int BCD_W   = 4 * (NUM_DIGITS - 1);
    localparam int BIT_CW  = $clog2(FRAME_W);
    localparam int DIV_W   = CLK_DIV_LOG2;

    state_e             state_q, state_d;
    logic               err_q;
    logic [2:0]         dp_q;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [BIT_CW-1:0]  bit_cnt_q;
    logic [DIV_W-1:0]   div_cnt_q, div_nxt;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ser_q, ser_d;
    logic               sclk_q, sclk_d;
    logic               latch_q, latch_d;

    logic               accept;
    logic               conv_start;
    logic               conv_done;
    logic               conv_ovf;
    logic [BCD_W-1:0]   conv_bcd;
    logic               div_last;
    logic               bit_last;

    // Upper half carries {g,f,a,b} per position MSD..LSD, lower half carries
    // {dp,e,d,c} per position LSD..MSD; position 0 is the unit glyph.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic             err,
        input logic [2:0]       dp,
        input logic [BCD_W-1:0] digits
    );
        logic [FRAME_W-1:0] f;
        logic [SYM_W-1:0]   sym;
        logic [6:0]         seg;
        logic [3:0]         nib;
        logic               lead;
        logic               dpb;
        int                 q;
        f    = '0;
        lead = BLANK_LZ;
        for (int p = NUM_DIGITS - 1; p >= 0; p--) begin
            q   = (p > 0) ? p - 1 : 0;
            nib = digits[4*q +: 4];
            if (err) begin
                sym = {1'b0, SYM_ERR};
            end else if (p == 0) begin
                sym = {1'b0, UNIT_CODE};
            end else if (lead && (nib == 4'd0) && (p > 1)) begin
                sym = SYM_BLANK;
            end else begin
                sym  = {1'b0, nib};
                lead = 1'b0;
            end
            dpb = !err && (p != 0) && (dp == 3'(p));
            seg = seg7(sym);
            f[4*NUM_DIGITS + 4*p +: 4]  = {seg[6], seg[5], seg[0], seg[1]};
            f[4*(NUM_DIGITS-1-p) +: 4]  = {dpb, seg[4], seg[3], seg[2]};
        end
        return f;
    endfunction

    bcd_dd_conv #(
        .VAL_W  (VAL_W),
        .DIGITS (NUM_DIGITS - 1)
    ) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .value (bus.value),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

    assign accept     = (state_q == IDLE) && bus.start;
    assign conv_start = accept && !bus.oor;
    assign div_nxt    = div_cnt_q + DIV_W'(1);
    assign div_last   = &div_cnt_q;
    assign bit_last   = (bit_cnt_q == BIT_CW'(FRAME_W - 1));
    assign frame_d    = build_frame(err_q | conv_ovf, dp_q, conv_bcd);

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ser_d   = ser_q;
        sclk_d  = 1'b0;
        latch_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    busy_d  = 1'b1;
                    state_d = bus.oor ? LOAD : CONVERT;
                end
            end
            CONVERT: begin
                if (conv_done) state_d = LOAD;
            end
            LOAD: begin
                state_d = SHIFT;
                ser_d   = frame_d[0] ^ INVERT_SER;
            end
            SHIFT: begin
                // Shift clock rises halfway through each bit period.
                sclk_d = div_nxt[DIV_W-1];
                if (div_last) begin
                    if (bit_last) begin
                        state_d = LATCH;
                        latch_d = 1'b1;
                    end else begin
                        ser_d = frame_q[1] ^ INVERT_SER;
                    end
                end
            end
            LATCH: begin
                if (div_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    latch_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ser_q     <= 1'b0;
            sclk_q    <= 1'b0;
            latch_q   <= 1'b0;
            err_q     <= 1'b0;
            dp_q      <= '0;
            frame_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ser_q   <= ser_d;
            sclk_q  <= sclk_d;
            latch_q <= latch_d;
            if (accept) begin
                err_q <= bus.oor;
                dp_q  <= bus.dp_pos;
            end
            case (state_q)
                LOAD: begin
                    frame_q   <= frame_d;
                    bit_cnt_q <= '0;
                    div_cnt_q <= '0;
                end
                SHIFT: begin
                    div_cnt_q <= div_nxt;
                    if (div_last && !bit_last) begin
                        bit_cnt_q <= bit_cnt_q + BIT_CW'(1);
                        frame_q   <= frame_q >> 1;
                    end
                end
                LATCH:   div_cnt_q <= div_nxt;
                default: ;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.seg_ser   = ser_q;
    assign bus.seg_clk   = sclk_q;
    assign bus.seg_latch = latch_q;

endmodule

// File: tb/tb_seg_serial_display.sv
// Directed bench for seg_serial_display with NUM_DIGITS=4, VAL_W=10, P=8;
// frames are rebuilt from the serial pins and compared to hand-derived words.
module tb_seg_serial_display;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    seg_serial_display_if #(.VAL_W(10)) bus();

    seg_serial_display #(
        .NUM_DIGITS   (4),
        .VAL_W        (10),
        .CLK_DIV_LOG2 (3),
        .UNIT_CODE    (4'hC),
        .BLANK_LZ     (1'b1),
        .INVERT_SER   (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one frame; cycle 1 is the cycle after the accept edge.
    task automatic do_frame(
        input  logic [9:0]  v,
        input  logic        o,
        input  logic [2:0]  dp,
        input  int          pulse_at,
        output logic [31:0] cap,
        output int          lat,
        output int          ndone,
        output int          nlat,
        output logic        busy_c1,
        output logic        busy_tail,
        output logic        ser_tail
    );
        logic clk_prev;
        int   n;
        cap = '0; lat = -1; ndone = 0; nlat = 0; clk_prev = 1'b0;
        busy_tail = 1'b0;
        @(negedge clk);
        bus.value = v; bus.oor = o; bus.dp_pos = dp; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.value = ~v; bus.oor = ~o; bus.dp_pos = ~dp;
        busy_c1 = bus.busy;
        n = 1;
        while (lat < 0 && n < 400) begin
            if (bus.seg_clk && !clk_prev) cap = {~bus.seg_ser, cap[31:1]};
            clk_prev = bus.seg_clk;
            if (bus.seg_latch) nlat++;
            if (bus.done) begin
                ndone++;
                lat = n;
            end
            bus.start = (n == pulse_at);
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.done) ndone++;
            busy_tail |= bus.busy;
            @(negedge clk);
        end
        ser_tail = bus.seg_ser;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total += 5;
        if (bus.busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        if (bus.done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        if (bus.seg_ser !== 1'b0)   begin bad++; $display("FAIL reset_ser got=%b exp=0", bus.seg_ser); end
        if (bus.seg_clk !== 1'b0)   begin bad++; $display("FAIL reset_clk got=%b exp=0", bus.seg_clk); end
        if (bus.seg_latch !== 1'b0) begin bad++; $display("FAIL reset_latch got=%b exp=0", bus.seg_latch); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_digits;
        logic [31:0] cap; int lat, nd, nl; logic b1, bt, st;
        do_frame(10'd237, 1'b0, 3'd2, 0, cap, lat, nd, nl, b1, bt, st);
        total += 7;
        if (cap !== 32'hBB3661B6) begin bad++; $display("FAIL digits_frame got=%h exp=BB3661B6", cap); end
        if (cap[31:28] !== 4'b1011) begin bad++; $display("FAIL digits_msd got=%b exp=1011", cap[31:28]); end
        if (lat !== 276) begin bad++; $display("FAIL digits_latency got=%0d exp=276", lat); end
        if (b1 !== 1'b1) begin bad++; $display("FAIL digits_busy_c1 got=%b exp=1", b1); end
        if (nd !== 1) begin bad++; $display("FAIL digits_done_count got=%0d exp=1", nd); end
        if (nl !== 8) begin bad++; $display("FAIL digits_latch_len got=%0d exp=8", nl); end
        if (st !== 1'b0) begin bad++; $display("FAIL digits_ser_hold got=%b exp=0", st); end
    endtask

    task automatic test_blanking;
        logic [31:0] cap; int lat, nd, nl; logic b1, bt, st;
        do_frame(10'd5, 1'b0, 3'd0, 0, cap, lat, nd, nl, b1, bt, st);
        total += 2;
        if (cap !== 32'h00E66300) begin bad++; $display("FAIL blank5_frame got=%h exp=00E66300", cap); end
        if (lat !== 276) begin bad++; $display("FAIL blank5_latency got=%0d exp=276", lat); end
        do_frame(10'd0, 1'b0, 3'd0, 0, cap, lat, nd, nl, b1, bt, st);
        total += 1;
        if (cap !== 32'h00766700) begin bad++; $display("FAIL zero_frame got=%h exp=00766700", cap); end
        do_frame(10'd40, 1'b0, 3'd7, 0, cap, lat, nd, nl, b1, bt, st);
        total += 1;
        if (cap !== 32'h0D766710) begin bad++; $display("FAIL v40_nodp_frame got=%h exp=0D766710", cap); end
    endtask

    task automatic test_max_value;
        logic [31:0] cap; int lat, nd, nl; logic b1, bt, st;
        do_frame(10'd999, 1'b0, 3'd1, 0, cap, lat, nd, nl, b1, bt, st);
        total += 1;
        if (cap !== 32'hFFF66B33) begin bad++; $display("FAIL v999_frame got=%h exp=FFF66B33", cap); end
    endtask

    task automatic test_oor;
        logic [31:0] cap; int lat, nd, nl; logic b1, bt, st;
        do_frame(10'd237, 1'b1, 3'd2, 0, cap, lat, nd, nl, b1, bt, st);
        total += 3;
        if (cap !== 32'hEEEE6666) begin bad++; $display("FAIL oor_frame got=%h exp=EEEE6666", cap); end
        if (lat !== 266) begin bad++; $display("FAIL oor_latency got=%0d exp=266", lat); end
        if (b1 !== 1'b1) begin bad++; $display("FAIL oor_busy_c1 got=%b exp=1", b1); end
    endtask

    task automatic test_overflow;
        logic [31:0] cap; int lat, nd, nl; logic b1, bt, st;
        do_frame(10'd1000, 1'b0, 3'd2, 0, cap, lat, nd, nl, b1, bt, st);
        total += 2;
        if (cap !== 32'hEEEE6666) begin bad++; $display("FAIL ovf_frame got=%h exp=EEEE6666", cap); end
        if (nd !== 1) begin bad++; $display("FAIL ovf_done_count got=%0d exp=1", nd); end
    endtask

    task automatic test_start_while_busy;
        logic [31:0] cap; int lat, nd, nl; logic b1, bt, st;
        do_frame(10'd237, 1'b0, 3'd2, 50, cap, lat, nd, nl, b1, bt, st);
        total += 4;
        if (cap !== 32'hBB3661B6) begin bad++; $display("FAIL busy_start_frame got=%h exp=BB3661B6", cap); end
        if (lat !== 276) begin bad++; $display("FAIL busy_start_latency got=%0d exp=276", lat); end
        if (nd !== 1) begin bad++; $display("FAIL busy_start_done_count got=%0d exp=1", nd); end
        if (bt !== 1'b0) begin bad++; $display("FAIL busy_start_tail_busy got=%b exp=0", bt); end
    endtask

    task automatic test_mid_reset;
        logic [31:0] cap; int lat, nd, nl; logic b1, bt, st;
        int stray;
        @(negedge clk);
        bus.value = 10'd237; bus.oor = 1'b0; bus.dp_pos = 3'd2; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (99) @(negedge clk);
        total += 1;
        if (bus.busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b exp=1", bus.busy); end
        rst_n = 1'b0;
        @(negedge clk);
        total += 5;
        if (bus.seg_clk !== 1'b0)   begin bad++; $display("FAIL midrst_clk got=%b exp=0", bus.seg_clk); end
        if (bus.seg_ser !== 1'b0)   begin bad++; $display("FAIL midrst_ser got=%b exp=0", bus.seg_ser); end
        if (bus.seg_latch !== 1'b0) begin bad++; $display("FAIL midrst_latch got=%b exp=0", bus.seg_latch); end
        if (bus.busy !== 1'b0)      begin bad++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
        if (bus.done !== 1'b0)      begin bad++; $display("FAIL midrst_done got=%b exp=0", bus.done); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 300; i++) begin
            if (bus.done || bus.busy) stray++;
            @(negedge clk);
        end
        total += 1;
        if (stray !== 0) begin bad++; $display("FAIL midrst_stray_activity got=%0d exp=0", stray); end
        do_frame(10'd237, 1'b0, 3'd2, 0, cap, lat, nd, nl, b1, bt, st);
        total += 2;
        if (cap !== 32'hBB3661B6) begin bad++; $display("FAIL midrst_refresh_frame got=%h exp=BB3661B6", cap); end
        if (lat !== 276) begin bad++; $display("FAIL midrst_refresh_latency got=%0d exp=276", lat); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.value  = '0;
        bus.oor    = 1'b0;
        bus.dp_pos = '0;
        bus.start  = 1'b0;
        test_reset();
        test_digits();
        test_blanking();
        test_max_value();
        test_oor();
        test_overflow();
        test_start_while_busy();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
